uc_multiciclo: RTL and testbench

//   Multi-cycle control unit for the simple CPU datapath (microc); replaces the hand-written

---
 rtl/uc_multiciclo_if.sv | 28 ++
 rtl/uc_multiciclo.sv | 129 ++++++++++++
 tb/tb_uc_multiciclo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uc_multiciclo_if.sv
// rtl/uc_multiciclo_if.sv - control-unit bus: datapath status in, control strobes out
// master drives start/Opcode/z and observes the controls; slave is the control unit.
interface uc_multiciclo_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [5:0]       Opcode;
  logic             z;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       Op;
  logic             pc_en;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal, instr_cnt
  );

  modport slave (
    input  start, Opcode, z,
    output s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal, instr_cnt
  );
endinterface

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multi-cycle FETCH/EXEC control unit for the microc datapath
// Optional retired-instruction counter enabled by defining UC_TRACE_EN.
module uc_multiciclo #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  uc_multiciclo_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] ir_q, ir_d;
  logic       illegal_q, illegal_d;

  logic       ir_is_halt;
  logic       ir_is_undef;
  logic       leaving_exec;

  logic       s_inc, s_inm, we3, wez, pc_en, halted;
  logic [2:0] op;

  // Only IR[5:2] selects behaviour; the low bits are latched but never decoded.
  logic       unused_ir;
  assign unused_ir = ^ir_q[1:0];

  assign ir_is_halt   = (ir_q[5:2] == 4'b0111);
  assign ir_is_undef  = !ir_q[5] && (ir_q[4:2] inside {3'b100, 3'b101, 3'b110});
  assign leaving_exec = (state_q == ST_EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= 6'b000000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        ir_d    = bus.Opcode;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ir_is_halt ? ST_HALT : ST_FETCH;
        if (ir_is_undef) illegal_d = 1'b1;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Controls are a pure function of state and IR; z only steers s_inc for JZ/JNZ.
  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op     = 3'b000;
    pc_en  = 1'b0;
    halted = (state_q == ST_HALT);
    if (state_q == ST_EXEC) begin
      pc_en = 1'b1;
      if (ir_q[5]) begin
        op  = ir_q[4:2];
        we3 = 1'b1;
        wez = 1'b1;
      end else begin
        case (ir_q[4:2])
          3'b000: begin
            s_inm = 1'b1;
            we3   = 1'b1;
          end
          3'b001:  s_inc = 1'b0;
          3'b010:  s_inc = !bus.z;
          3'b011:  s_inc = bus.z;
          3'b111:  pc_en = 1'b0;
          default: s_inc = 1'b1;
        endcase
      end
    end
  end

  assign bus.s_inc   = s_inc;
  assign bus.s_inm   = s_inm;
  assign bus.we3     = we3;
  assign bus.wez     = wez;
  assign bus.Op      = op;
  assign bus.pc_en   = pc_en;
  assign bus.halted  = halted;
  assign bus.illegal = illegal_q;

`ifdef UC_TRACE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating: once all-ones the count is frozen rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (leaving_exec && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.instr_cnt = cnt_q;
`else
  logic unused_leaving_exec;
  assign unused_leaving_exec = leaving_exec;
  assign bus.instr_cnt       = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - scoreboard bench for uc_multiciclo
// Expected EXEC controls are queued as each opcode is driven and compared in its EXEC cycle.
module tb_uc_multiciclo;

  localparam int CNT_W = 16;

  // Packed control vector: {s_inc, s_inm, we3, wez, Op[2:0], pc_en, halted}
  localparam logic [8:0] V_IDLE = 9'b1_0_0_0_000_0_0;
  localparam logic [8:0] V_HALT = 9'b1_0_0_0_000_0_1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  uc_multiciclo_if #(.CNT_W(CNT_W)) bus ();

  uc_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ctl_vec();
    return {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.Op, bus.pc_en, bus.halted};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at a negedge with the DUT in FETCH.
  task automatic do_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check_eq("fetch_after_start", 32'(ctl_vec()), 32'(V_IDLE));
  endtask

  // Called at a negedge in FETCH; returns at the next negedge after EXEC.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic zv,
                           input logic [8:0] exp);
    logic [8:0] e;
    bus.Opcode = op;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.z = zv;
    bus.Opcode = ~op;
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(ctl_vec()), 32'(e));
    end
    @(negedge clk);
  endtask

  logic [CNT_W-1:0] exp_cnt;

  initial begin
    bus.start  = 1'b0;
    bus.Opcode = 6'b000000;
    bus.z      = 1'b0;
    #12;
    check_eq("reset_ctl", 32'(ctl_vec()), 32'(V_IDLE));
    check_eq("reset_illegal", 32'(bus.illegal), 32'd0);
    check_eq("reset_cnt", 32'(bus.instr_cnt), 32'd0);
    @(negedge clk) reset = 1'b0;

    // start must be sampled in IDLE; held low the unit stays idle
    repeat (3) @(negedge clk);
    check_eq("idle_wait", 32'(ctl_vec()), 32'(V_IDLE));

    do_start();
    run_instr("li",       6'b000000, 1'b0, 9'b1_1_1_0_000_1_0);
    check_eq("fetch_ctl", 32'(ctl_vec()), 32'(V_IDLE));
    run_instr("alu_101",  6'b110100, 1'b0, 9'b1_0_1_1_101_1_0);
    run_instr("jz_z1",    6'b001000, 1'b1, 9'b0_0_0_0_000_1_0);
    run_instr("jz_z0",    6'b001000, 1'b0, 9'b1_0_0_0_000_1_0);
    run_instr("jnz_z1",   6'b001100, 1'b1, 9'b1_0_0_0_000_1_0);
    run_instr("jnz_z0",   6'b001100, 1'b0, 9'b0_0_0_0_000_1_0);
    run_instr("j",        6'b000111, 1'b1, 9'b0_0_0_0_000_1_0);
    check_eq("illegal_clear", 32'(bus.illegal), 32'd0);
    run_instr("nop_undef", 6'b010000, 1'b0, 9'b1_0_0_0_000_1_0);
    check_eq("illegal_set", 32'(bus.illegal), 32'd1);
    run_instr("alu_010",  6'b101011, 1'b1, 9'b1_0_1_1_010_1_0);
    run_instr("nop_110",  6'b011000, 1'b0, 9'b1_0_0_0_000_1_0);
    check_eq("illegal_sticky", 32'(bus.illegal), 32'd1);
    run_instr("halt_exec", 6'b011100, 1'b0, 9'b1_0_0_0_000_0_0);
    check_eq("halt_state", 32'(ctl_vec()), 32'(V_HALT));
`ifdef UC_TRACE_EN
    exp_cnt = 16'd11;
`else
    exp_cnt = '0;
`endif
    check_eq("cnt_run1", 32'(bus.instr_cnt), 32'(exp_cnt));

    // Three instructions then HALT from a fresh reset
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    do_start();
    run_instr("r2_li",  6'b000001, 1'b0, 9'b1_1_1_0_000_1_0);
    run_instr("r2_alu", 6'b111110, 1'b0, 9'b1_0_1_1_111_1_0);
    run_instr("r2_jnz", 6'b001101, 1'b1, 9'b1_0_0_0_000_1_0);
    run_instr("r2_halt", 6'b011111, 1'b0, 9'b1_0_0_0_000_0_0);
`ifdef UC_TRACE_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = '0;
`endif
    check_eq("cnt_halt4", 32'(bus.instr_cnt), 32'(exp_cnt));
    check_eq("r2_illegal", 32'(bus.illegal), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
    end
    repeat (4) @(negedge clk);
    check_eq("halt_ignores_start", 32'(ctl_vec()), 32'(V_HALT));
    check_eq("cnt_frozen", 32'(bus.instr_cnt), 32'(exp_cnt));

    // Reset asserted mid-EXEC of an ALU op after illegal was set
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    do_start();
    run_instr("r3_undef", 6'b010100, 1'b0, 9'b1_0_0_0_000_1_0);
    check_eq("r3_illegal", 32'(bus.illegal), 32'd1);
    bus.Opcode = 6'b100100;
    @(negedge clk);
    #1;
    check_eq("r3_alu_exec", 32'(ctl_vec()), 32'(9'b1_0_1_1_001_1_0));
    reset = 1'b1;
    #1;
    check_eq("midexec_reset_ctl", 32'(ctl_vec()), 32'(V_IDLE));
    check_eq("midexec_reset_illegal", 32'(bus.illegal), 32'd0);
    check_eq("midexec_reset_cnt", 32'(bus.instr_cnt), 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", 32'(ctl_vec()), 32'(V_IDLE));
    do_start();
    run_instr("r3_li", 6'b000000, 1'b0, 9'b1_1_1_0_000_1_0);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
